// File: rtl/react_timer_multi.sv
// Multi-player reaction timer.
//
// A start pulse arms a round. After a pseudo-random delay of 1000..3047 ms the led
// lights and a BCD millisecond counter runs. Each channel latches the counter on its
// first debounced press. Pressing before the led lights marks the channel as a false
// start. When the round ends, the fastest valid channel is reported.
//
// Parameters: N_CH (channels, 1..8), DIGITS (BCD digits), CLK_HZ (clock frequency),
//             DB_MS (debounce window, in ms).
// Ports:
//   clk, rst      system clock; asynchronous active-high reset
//   start         single-cycle pulse that starts a round (honoured in IDLE/DONE only)
//   btn[N_CH]     raw active-high buttons
//   led           go-stimulus lamp
//   busy / done   round in progress / round finished
//   times         per-channel BCD times, channel 0 in the LSBs
//   false_start   per-channel early-press flags
//   winner        index of the fastest valid channel
//   no_winner     no channel captured a valid time
// Optional macro: REACT_BLANK_EN shows leading zero digits as 4'hF.
module react_timer_multi #(
  parameter int unsigned N_CH   = 2,
  parameter int unsigned DIGITS = 4,
  parameter int unsigned CLK_HZ = 50000000,
  parameter int unsigned DB_MS  = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [N_CH-1:0]          btn,
  output logic                     led,
  output logic                     busy,
  output logic                     done,
  output logic [N_CH*DIGITS*4-1:0] times,
  output logic [N_CH-1:0]          false_start,
  output logic [2:0]               winner,
  output logic                     no_winner
);

  localparam int unsigned W         = DIGITS * 4;
  localparam logic [31:0] TickMax   = 32'(CLK_HZ / 1000 - 1);
  localparam logic [7:0]  DbMax     = 8'(DB_MS - 1);
  localparam logic [W-1:0] AllNines = {DIGITS{4'h9}};
  localparam logic [N_CH-1:0] AllCh = '1;

  typedef enum logic [1:0] {StIdle, StWait, StRun, StDone} state_e;

  // 1 ms tick
  logic [31:0] div_q;
  logic        tick;

  assign tick = (div_q == TickMax);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
    end else if (tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 32'd1;
    end
  end

  // Free-running Fibonacci LFSR, taps 16,14,13,11
  logic [15:0] lfsr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  // Synchroniser and debouncer per channel
  logic [N_CH-1:0] sync1_q, sync2_q, db_q, db_prev_q, press;
  logic [7:0]      db_cnt_q [N_CH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      for (int i = 0; i < N_CH; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q   <= btn;
      sync2_q   <= sync1_q;
      db_prev_q <= db_q;
      for (int i = 0; i < N_CH; i++) begin
        // Any cycle back at the debounced level restarts the stability window.
        if (sync2_q[i] == db_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (tick) begin
          if (db_cnt_q[i] == DbMax) begin
            db_q[i]     <= sync2_q[i];
            db_cnt_q[i] <= '0;
          end else begin
            db_cnt_q[i] <= db_cnt_q[i] + 8'd1;
          end
        end
      end
    end
  end

  assign press = db_q & ~db_prev_q;

  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (c) begin
        if (r[d*4 +: 4] == 4'd9) begin
          r[d*4 +: 4] = 4'd0;
        end else begin
          r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Round state
  state_e          state_q;
  logic [11:0]     delay_q;
  logic [W-1:0]    cnt_q;
  logic [W-1:0]    slot_q [N_CH];
  logic [N_CH-1:0] cap_q;
  logic [N_CH-1:0] fs_q;

  // Next-cycle view of captures, used so the winner is ready on DONE entry
  logic [N_CH-1:0] cap_now, cap_nxt, fs_nxt;
  logic            sat;
  logic [W-1:0]    slot_nxt [N_CH];
  logic [2:0]      win_idx;
  logic            any_cap;
  logic [W-1:0]    best;

  always_comb begin
    cap_now = '0;
    if (state_q == StRun) cap_now = press & ~cap_q & ~fs_q;
    cap_nxt = cap_q | cap_now;
    sat     = (state_q == StRun) && tick && (cnt_q == AllNines);
    fs_nxt  = fs_q;
    if (state_q == StWait) fs_nxt = fs_q | press;
    for (int i = 0; i < N_CH; i++) begin
      slot_nxt[i] = slot_q[i];
      if (cap_now[i]) begin
        slot_nxt[i] = cnt_q;
      end else if (fs_nxt[i] || (sat && !cap_q[i])) begin
        slot_nxt[i] = AllNines;
      end
    end
    // Strict less-than keeps the lowest index on ties; BCD orders like binary.
    win_idx = '0;
    any_cap = 1'b0;
    best    = AllNines;
    for (int i = 0; i < N_CH; i++) begin
      if (cap_nxt[i] && (!any_cap || slot_nxt[i] < best)) begin
        any_cap = 1'b1;
        best    = slot_nxt[i];
        win_idx = 3'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      delay_q   <= '0;
      cnt_q     <= '0;
      cap_q     <= '0;
      fs_q      <= '0;
      led       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      winner    <= '0;
      no_winner <= 1'b0;
      for (int i = 0; i < N_CH; i++) slot_q[i] <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            for (int i = 0; i < N_CH; i++) slot_q[i] <= '0;
            cap_q     <= '0;
            fs_q      <= '0;
            winner    <= '0;
            no_winner <= 1'b0;
            delay_q   <= 12'd1000 + {1'b0, lfsr_q[10:0]};
            busy      <= 1'b1;
            done      <= 1'b0;
            led       <= 1'b0;
            state_q   <= StWait;
          end
        end
        StWait: begin
          fs_q <= fs_nxt;
          for (int i = 0; i < N_CH; i++) slot_q[i] <= slot_nxt[i];
          if (fs_nxt == AllCh) begin
            busy      <= 1'b0;
            done      <= 1'b1;
            winner    <= '0;
            no_winner <= 1'b1;
            state_q   <= StDone;
          end else if (tick) begin
            if (delay_q == 12'd1) begin
              led     <= 1'b1;
              cnt_q   <= '0;
              state_q <= StRun;
            end else begin
              delay_q <= delay_q - 12'd1;
            end
          end
        end
        StRun: begin
          cap_q <= cap_nxt;
          for (int i = 0; i < N_CH; i++) slot_q[i] <= slot_nxt[i];
          if (((cap_nxt | fs_q) == AllCh) || sat) begin
            led       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            winner    <= win_idx;
            no_winner <= !any_cap;
            state_q   <= StDone;
          end else if (tick) begin
            cnt_q <= bcd_inc(cnt_q);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign false_start = fs_q;

  // Display formatting
  logic [W-1:0] disp [N_CH];
`ifdef REACT_BLANK_EN
  logic lead;
`endif

  always_comb begin
    times = '0;
`ifdef REACT_BLANK_EN
    lead = 1'b1;
`endif
    for (int i = 0; i < N_CH; i++) begin
      disp[i] = slot_q[i];
`ifdef REACT_BLANK_EN
      lead = 1'b1;
      for (int d = DIGITS - 1; d >= 1; d--) begin
        if (lead && slot_q[i][d*4 +: 4] == 4'd0) begin
          disp[i][d*4 +: 4] = 4'hF;
        end else begin
          lead = 1'b0;
        end
      end
`endif
      times[i*W +: W] = disp[i];
    end
  end

endmodule
